// File: rtl/stc_tile_sequencer.sv
// Tile sequencer for stc_core: streams A/B/C/control words into the core write ports,
// buffers the M output rows of D and drains them on a valid/ready stream.
module stc_tile_sequencer #(
    parameter int M           = 16,
    parameter int N           = 16,
    parameter int DW_MEM      = 256,
    parameter int DW_DATA     = 16,
    parameter int DW_IDX      = 4,
    parameter int MAX_A_WORDS = 16,
    parameter int DW_CNT      = $clog2(MAX_A_WORDS + 1),
    parameter int TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DW_CNT-1:0]       a_words,
    input  logic                    load_c,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DW_MEM-1:0]       s_data,
    output logic                    write_a_data_en,
    output logic                    write_a_cidx_en,
    output logic [DW_MEM-1:0]       A_data_input,
    output logic [DW_MEM-1:0]       A_colidx_input,
    output logic [DW_IDX-1:0]       A_idx,
    output logic                    write_b,
    output logic [DW_MEM-1:0]       B_input,
    output logic [DW_IDX-1:0]       B_row,
    output logic                    write_c,
    output logic [N*DW_DATA-1:0]    in_c,
    output logic [DW_IDX-1:0]       in_c_row,
    output logic                    write_cu,
    output logic [DW_MEM-1:0]       cu_input,
    input  logic                    core_out_valid,
    input  logic [N*DW_DATA-1:0]    core_out_d,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N*DW_DATA-1:0]    m_data,
    output logic                    m_last
);
    // state     | meaning
    // S_IDLE    | waiting for start
    // S_LOAD_A  | A data / column-index word pairs
    // S_LOAD_B  | M B rows
    // S_LOAD_C  | M C rows from stream, or M zero rows
    // S_LOAD_CU | control word, then one cycle for its strobe
    // S_COMPUTE | collecting D rows, timeout running
    // S_DRAIN   | D rows out on the m_ stream

    localparam int DW_D = N * DW_DATA;
    localparam int CW   = ($clog2(M + 1) > DW_CNT) ? $clog2(M + 1) : DW_CNT;
    localparam int PW   = (M > 1) ? $clog2(M) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]     C_MLAST = CW'(M - 1);
    localparam logic [PW-1:0]     P_MLAST = PW'(M - 1);
    localparam logic [TW-1:0]     T_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [DW_CNT-1:0] C_MAXA  = DW_CNT'(MAX_A_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_LOAD_CU, S_COMPUTE, S_DRAIN
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_half;
    logic [DW_CNT-1:0]   r_a_words;
    logic                r_load_c;
    logic [DW_MEM-1:0]   r_a_hold;
    logic [TW-1:0]       r_tmr;
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [DW_D-1:0]     r_dbuf [M];

    logic                w_s_ready, w_acc, w_start_ok, w_start_bad, w_a_last;
    logic [CW-1:0]       w_cnt_inc;

    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_a_last    = (w_cnt_inc == CW'(r_a_words));
    assign w_start_ok  = start && (a_words <= C_MAXA);
    assign w_start_bad = start && (a_words > C_MAXA);
    assign w_acc       = s_valid && w_s_ready;
    assign s_ready     = w_s_ready;

    assign m_valid = (r_state == S_DRAIN);
    assign m_data  = m_valid ? r_dbuf[r_rptr] : '0;
    assign m_last  = m_valid && (r_rptr == P_MLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_s_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = (a_words == '0) ? S_LOAD_B : S_LOAD_A;
            end
            S_LOAD_A: begin
                w_s_ready = 1'b1;
                if (w_acc && r_half && w_a_last) w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_s_ready = 1'b1;
                if (w_acc && r_cnt == C_MLAST) w_next = S_LOAD_C;
            end
            S_LOAD_C: begin
                w_s_ready = r_load_c;
                if ((w_acc || !r_load_c) && r_cnt == C_MLAST) w_next = S_LOAD_CU;
            end
            S_LOAD_CU: begin
                // hold off while the last zero-fill strobe is still out
                w_s_ready = (r_cnt == '0) && !(write_c && !r_load_c);
                if (r_cnt != '0) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (core_out_valid && r_wptr == P_MLAST) w_next = S_DRAIN;
                else if (r_tmr == '0)                    w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (m_ready && r_rptr == P_MLAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;  done <= 1'b0;  err <= 2'b00;
            write_a_data_en <= 1'b0;  write_a_cidx_en <= 1'b0;
            A_data_input <= '0;  A_colidx_input <= '0;  A_idx <= '0;
            write_b <= 1'b0;  B_input <= '0;  B_row <= '0;
            write_c <= 1'b0;  in_c <= '0;  in_c_row <= '0;
            write_cu <= 1'b0;  cu_input <= '0;
            r_cnt <= '0;  r_half <= 1'b0;  r_a_words <= '0;  r_load_c <= 1'b0;
            r_a_hold <= '0;  r_tmr <= '0;  r_wptr <= '0;  r_rptr <= '0;
        end else begin
            write_a_data_en <= 1'b0;
            write_a_cidx_en <= 1'b0;
            write_b         <= 1'b0;
            write_c         <= 1'b0;
            write_cu        <= 1'b0;
            done            <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        busy      <= 1'b1;
                        err       <= 2'b00;
                        r_a_words <= a_words;
                        r_load_c  <= load_c;
                        r_half    <= 1'b0;
                    end else if (w_start_bad) begin
                        err[1] <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    if (w_acc && !r_half) begin
                        r_a_hold <= s_data;
                        r_half   <= 1'b1;
                    end else if (w_acc) begin
                        r_half          <= 1'b0;
                        write_a_data_en <= 1'b1;
                        write_a_cidx_en <= 1'b1;
                        A_data_input    <= r_a_hold;
                        A_colidx_input  <= s_data;
                        A_idx           <= r_cnt[DW_IDX-1:0];
                        r_cnt           <= w_a_last ? '0 : w_cnt_inc;
                    end
                end
                S_LOAD_B: begin
                    if (w_acc) begin
                        write_b <= 1'b1;
                        B_input <= s_data;
                        B_row   <= r_cnt[DW_IDX-1:0];
                        r_cnt   <= (r_cnt == C_MLAST) ? '0 : w_cnt_inc;
                    end
                end
                S_LOAD_C: begin
                    if (w_acc || !r_load_c) begin
                        write_c  <= 1'b1;
                        in_c     <= r_load_c ? s_data[DW_D-1:0] : '0;
                        in_c_row <= r_cnt[DW_IDX-1:0];
                        r_cnt    <= (r_cnt == C_MLAST) ? '0 : w_cnt_inc;
                    end
                end
                S_LOAD_CU: begin
                    if (w_acc) begin
                        write_cu <= 1'b1;
                        cu_input <= s_data;
                        r_cnt    <= w_cnt_inc;
                    end else if (r_cnt != '0) begin
                        r_cnt <= '0;
                        r_tmr <= T_LOAD;
                    end
                end
                S_COMPUTE: begin
                    if (core_out_valid) r_wptr <= (r_wptr == P_MLAST) ? '0 : r_wptr + 1'b1;
                    if (w_next == S_IDLE) begin
                        err[0] <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        r_wptr <= '0;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (m_ready) begin
                        r_rptr <= (r_rptr == P_MLAST) ? '0 : r_rptr + 1'b1;
                        if (r_rptr == P_MLAST) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_COMPUTE && core_out_valid) r_dbuf[r_wptr] <= core_out_d;
    end

endmodule

// File: tb/tb_stc_tile_sequencer.sv
// Bench for stc_tile_sequencer: per-tile expectations are derived from the word list
// (A pairs, B rows, C rows, control word, D rows) and checked by one negedge monitor.
module tb_stc_tile_sequencer;
    localparam int M = 16, N = 16, DW_MEM = 256, DW_DATA = 16, DW_IDX = 4;
    localparam int MAXA = 16, DW_CNT = 5, TO = 64;
    localparam int DWD = N * DW_DATA;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, load_c = 1'b0;
    logic [DW_CNT-1:0] a_words = '0;
    logic busy, done, s_ready, s_valid, m_valid, m_ready, m_last, core_out_valid;
    logic [1:0] err;
    logic [DW_MEM-1:0] s_data, A_data_input, A_colidx_input, B_input, cu_input;
    logic write_a_data_en, write_a_cidx_en, write_b, write_c, write_cu;
    logic [DW_IDX-1:0] A_idx, B_row, in_c_row;
    logic [DWD-1:0] in_c, core_out_d, m_data;

    stc_tile_sequencer #(.M(M), .N(N), .DW_MEM(DW_MEM), .DW_DATA(DW_DATA), .DW_IDX(DW_IDX),
                         .MAX_A_WORDS(MAXA), .DW_CNT(DW_CNT), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .a_words(a_words), .load_c(load_c),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .write_a_data_en(write_a_data_en), .write_a_cidx_en(write_a_cidx_en),
        .A_data_input(A_data_input), .A_colidx_input(A_colidx_input), .A_idx(A_idx),
        .write_b(write_b), .B_input(B_input), .B_row(B_row),
        .write_c(write_c), .in_c(in_c), .in_c_row(in_c_row),
        .write_cu(write_cu), .cu_input(cu_input),
        .core_out_valid(core_out_valid), .core_out_d(core_out_d),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // tile model
    logic [255:0] words [80];
    logic [255:0] ea_data [M], ea_cidx [M], eb [M], ecu;
    logic [DWD-1:0] ec [M], d_rows [M];
    int cur_aw, cur_lc;

    // monitor state
    bit mon_en = 1'b0, prev_stall = 1'b0;
    logic [DWD-1:0] prev_md;
    int a_seen, b_seen, c_seen, cu_seen, d_seen, n_acc, n_sready, mv_cyc;
    int c_first, c_last, cu_cyc, done_cyc, last_hs_cyc, last_acc_cyc, done_cnt;

    always @(negedge clk) begin
        if (mon_en) begin
            int nst;
            nst = int'(write_a_data_en) + int'(write_b) + int'(write_c) + int'(write_cu);
            if (nst > 0) checki("strobe_onehot", nst, 1);
            if (write_a_data_en || write_a_cidx_en) begin
                checki("a_strobe_pair", int'(write_a_data_en), int'(write_a_cidx_en));
                checki("a_latency", cyc - last_acc_cyc, 1);
                if (a_seen < cur_aw) begin
                    checki("A_idx", int'(A_idx), a_seen);
                    check("A_data", A_data_input, ea_data[a_seen]);
                    check("A_cidx", A_colidx_input, ea_cidx[a_seen]);
                end else checki("a_extra", a_seen + 1, cur_aw);
                a_seen++;
            end
            if (write_b) begin
                checki("b_after_a", a_seen, cur_aw);
                checki("b_latency", cyc - last_acc_cyc, 1);
                if (b_seen < M) begin
                    checki("B_row", int'(B_row), b_seen);
                    check("B_input", B_input, eb[b_seen]);
                end else checki("b_extra", b_seen + 1, M);
                b_seen++;
            end
            if (write_c) begin
                checki("c_after_b", b_seen, M);
                if (cur_lc == 0) checki("zfill_sready_low", int'(s_ready), 0);
                else checki("c_latency", cyc - last_acc_cyc, 1);
                if (c_seen < M) begin
                    checki("in_c_row", int'(in_c_row), c_seen);
                    check("in_c", in_c, ec[c_seen]);
                end else checki("c_extra", c_seen + 1, M);
                if (c_seen == 0) c_first = cyc;
                c_last = cyc;
                c_seen++;
            end
            if (write_cu) begin
                checki("cu_after_c", c_seen, M);
                checki("cu_latency", cyc - last_acc_cyc, 1);
                check("cu_input", cu_input, ecu);
                cu_cyc = cyc;
                cu_seen++;
            end
            if (m_valid) begin
                mv_cyc++;
                checki("d_after_cu", cu_seen, 1);
                if (prev_stall) check("m_data_stable", m_data, prev_md);
                if (d_seen < M) begin
                    check("m_data", m_data, d_rows[d_seen]);
                    checki("m_last", int'(m_last), int'(d_seen == M - 1));
                end else checki("d_extra", d_seen + 1, M);
                if (m_ready) begin
                    if (m_last) last_hs_cyc = cyc;
                    d_seen++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_md = m_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checki("busy_low_at_done", int'(busy), 0);
            end
            if (s_valid && s_ready) begin
                n_acc++;
                last_acc_cyc = cyc;
            end
            if (s_ready) n_sready++;
        end
    end

    task automatic check_zero(input string nm);
        checki(nm, int'(|{busy, done, err, s_ready, write_a_data_en, write_a_cidx_en, A_data_input,
                          A_colidx_input, A_idx, write_b, B_input, B_row, write_c, in_c, in_c_row,
                          write_cu, cu_input, m_valid, m_data, m_last}), 0);
    endtask

    task automatic run_tile(input int aw, input bit lc, input bit gaps, input bit core_en,
                            input bit abort_b);
        int nw, si, rs, budget;
        bit acc;
        nw = 2 * aw + M + (lc ? M : 0) + 1;
        for (int k = 0; k < nw; k++) words[k] = rnd256();
        for (int r = 0; r < aw; r++) begin
            ea_data[r] = words[2 * r];
            ea_cidx[r] = words[2 * r + 1];
        end
        for (int r = 0; r < M; r++) begin
            eb[r] = words[2 * aw + r];
            ec[r] = lc ? words[2 * aw + M + r][DWD-1:0] : '0;
            d_rows[r] = rnd256();
        end
        ecu = words[nw - 1];
        cur_aw = aw; cur_lc = int'(lc);
        a_seen = 0; b_seen = 0; c_seen = 0; cu_seen = 0; d_seen = 0; n_acc = 0; n_sready = 0;
        mv_cyc = 0; c_first = 0; c_last = 0; cu_cyc = 0; done_cyc = 0; last_hs_cyc = 0;
        last_acc_cyc = -10; done_cnt = 0; prev_stall = 1'b0; mon_en = 1'b1;

        @(posedge clk); #1;
        start = 1'b1; a_words = DW_CNT'(aw); load_c = lc;
        @(posedge clk); #1;
        start = 1'b0; a_words = DW_CNT'(aw ^ 1); load_c = !lc;
        s_valid = 1'b1; s_data = words[0];
        @(negedge clk);
        checki("busy_rise", int'(busy), 1);
        checki("err_cleared", int'(err), 0);

        si = 0; rs = 0; budget = 0;
        while (done_cnt == 0 && budget < 3000 && !(abort_b && b_seen >= 3)) begin
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) si++;
            s_valid = (si < nw) && (!gaps || $urandom_range(1, 0) == 1);
            s_data  = (si < nw) ? words[si] : '0;
            start   = gaps && cu_seen == 0 && $urandom_range(3, 0) == 0;
            if (core_en && cu_seen > 0 && rs < M) begin
                core_out_valid = !gaps || $urandom_range(1, 0) == 1;
                core_out_d = d_rows[rs];
                if (core_out_valid) rs++;
            end else begin
                core_out_valid = gaps && $urandom_range(1, 0) == 1;
                core_out_d = rnd256();
            end
            m_ready = !gaps || $urandom_range(1, 0) == 1;
            @(negedge clk);
            budget++;
        end
        start = 1'b0; core_out_valid = 1'b0;

        if (abort_b) begin
            #3 reset = 1'b0;
            #1 check_zero("async_reset_outputs");
            mon_en = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
            @(negedge clk); reset = 1'b1;
            @(negedge clk);
            check_zero("idle_after_reset");
        end else begin
            if (budget >= 3000) checki("tile_complete", 0, 1);
            s_valid = 1'b0; m_ready = 1'b1;
            repeat (2) @(negedge clk);
            checki("done_once", done_cnt, 1);
            checki("busy_after", int'(busy), 0);
            checki("a_rows", a_seen, aw);
            checki("b_rows", b_seen, M);
            checki("c_rows", c_seen, M);
            checki("cu_count", cu_seen, 1);
            checki("words_consumed", n_acc, nw);
            if (!gaps) checki("load_cycles", n_sready, nw);
            if (!lc) checki("zfill_consecutive", c_last - c_first, M - 1);
            if (core_en) begin
                checki("d_rows_out", d_seen, M);
                checki("done_latency", done_cyc - last_hs_cyc, 1);
                checki("err_ok", int'(err), 0);
            end else begin
                checki("timeout_latency", done_cyc - cu_cyc, TO + 1);
                checki("timeout_err", int'(err), 1);
                checki("timeout_no_mvalid", mv_cyc, 0);
            end
            mon_en = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid = 1'b0; s_data = '0; core_out_valid = 1'b0; core_out_d = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        reset = 1'b1;
        @(negedge clk);
        check_zero("idle_outputs");

        // a_words above the maximum: flagged, nothing consumed
        @(posedge clk); #1;
        start = 1'b1; a_words = 5'd17; load_c = 1'b1; s_valid = 1'b1; s_data = rnd256();
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checki("bad_busy", int'(busy), 0);
            checki("bad_sready", int'(s_ready), 0);
            checki("bad_err", int'(err), 2);
        end
        s_valid = 1'b0;

        run_tile(4, 1'b1, 1'b0, 1'b1, 1'b0);
        checki("nominal_words_41", n_acc, 41);
        checki("nominal_a_rows_4", a_seen, 4);
        run_tile(2, 1'b0, 1'b0, 1'b1, 1'b0);
        checki("zfill_words_21", n_acc, 21);
        run_tile(0, 1'b1, 1'b0, 1'b1, 1'b0);
        checki("a0_words_33", n_acc, 33);
        run_tile(3, 1'b1, 1'b1, 1'b1, 1'b0);
        run_tile(16, 1'b0, 1'b1, 1'b1, 1'b0);
        checki("a16_words_49", n_acc, 49);
        run_tile(1, 1'b1, 1'b0, 1'b0, 1'b0);
        checki("timeout_err_literal", int'(err), 1);
        run_tile(2, 1'b1, 1'b0, 1'b1, 1'b1);
        run_tile(5, 1'b1, 1'b0, 1'b1, 1'b0);
        checki("fresh_words_43", n_acc, 43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stc_tile_sequencer.md
# stc_tile_sequencer

Hardware successor to the bench-side loader for `stc_core`. It streams one tile's worth of memory words from a valid/ready source into the core's write ports in a fixed order: A values and column indices, then B rows, then C rows, then the control word. It then collects the M output rows of D into an internal buffer and drains them on a valid/ready stream. It adds features the software loader lacks: a parametrised A depth, an optional C load (zero-fill mode), source backpressure tolerance, output backpressure buffering, a compute timeout, and error reporting.

## Interface
Parameters:
- `M`, 16: rows of A/B/C/D, and the number of D rows collected per tile.
- `N`, 16: columns of D (`m_data` = N*DW_DATA).
- `DW_MEM`, 256: source word width.
- `DW_DATA`, 16: element width.
- `DW_IDX`, 4: width of `A_idx`, `B_row` and `in_c_row`.
- `MAX_A_WORDS`, 16: maximum A rows per tile. Must be ≤ 2^DW_IDX.
- `DW_CNT`, $clog2(MAX_A_WORDS+1): width of `a_words`.
- `TIMEOUT`, 1024: maximum COMPUTE cycles before abort.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: tile request, sampled only in IDLE.
- `a_words` in DW_CNT: number of A rows in the tile; 0 is legal.
- `load_c` in 1: 1 = take C rows from the stream; 0 = zero-fill C.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse at tile end.
- `err` out 2: sticky, cleared by an accepted start. [0] = timeout, [1] = bad `a_words`.
- `s_valid` in 1, `s_ready` out 1, `s_data` in DW_MEM: source stream.
- `write_a_data_en`, `write_a_cidx_en` out 1: A write strobes to the core.
- `A_data_input`, `A_colidx_input` out DW_MEM: A write data.
- `A_idx` out DW_IDX: A row index.
- `write_b` out 1, `B_input` out DW_MEM, `B_row` out DW_IDX: B write port.
- `write_c` out 1, `in_c` out N*DW_DATA, `in_c_row` out DW_IDX: C write port.
- `write_cu` out 1, `cu_input` out DW_MEM: control write port.
- `core_out_valid` in 1, `core_out_d` in N*DW_DATA: D rows from the core; the core applies no backpressure.
- `m_valid` out 1, `m_ready` in 1, `m_data` out N*DW_DATA, `m_last` out 1: D output stream.

## Operation
- State sequence: IDLE → LOAD_A → LOAD_B → LOAD_C → LOAD_CU → COMPUTE → DRAIN → IDLE.
- Start handling in IDLE:
  - `start` with `a_words` > MAX_A_WORDS: set err[1], stay in IDLE, consume no words.
  - `start` with a legal `a_words`: clear `err`, latch `a_words` and `load_c`.
- LOAD_A: consumes 2 words per A row, data word first, then column-index word.
  - The data word is held in a register.
  - On acceptance of the index word, the next cycle pulses both A strobes with `A_idx` = row (0..a_words-1), held data, and the index word.
  - Skipped when `a_words` = 0.
- LOAD_B: consumes M words. Each accepted word produces a `write_b` pulse on the next cycle, `B_row` 0..M-1, `B_input` = word.
- LOAD_C:
  - `load_c`=1: consumes M words; `in_c` = low N*DW_DATA bits of each word, `in_c_row` 0..M-1.
  - `load_c`=0: `s_ready` stays low and the block issues M back-to-back `write_c` pulses with `in_c`=0.
- LOAD_CU: consumes 1 word and produces a one-cycle `write_cu` pulse with `cu_input` = word.
- `s_ready` is 1 in every stream-consuming state until the phase count is reached, and 0 everywhere else.
- COMPUTE:
  - Each `core_out_valid` cycle writes `core_out_d` into the D buffer (M entries) at the write pointer.
  - Move to DRAIN after the M-th row.
  - `core_out_valid` outside COMPUTE is ignored.
- Timeout: a COMPUTE cycle counter reaching TIMEOUT sets err[0], pulses `done`, returns to IDLE, and discards the buffer.
- DRAIN: rows leave in arrival order; `m_last` is high on row M-1.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and pointers 0.
- Reset takes effect asynchronously and immediately, including mid-tile; any partial tile is discarded.
- `busy` rises the cycle after an accepted `start`.
- All core-side outputs are registered: each strobe is high exactly 1 cycle after the accepting handshake. Strobes never overlap across phases.
- With `s_valid` held high, the load phase lasts 2·a_words + M + M·load_c + 1 cycles.
- Zero-fill C issues M pulses on consecutive cycles.
- COMPUTE is entered the cycle after the `write_cu` pulse.
- DRAIN:
  - `m_valid` goes high on the first DRAIN cycle.
  - `m_data` and `m_last` stay stable while `m_valid`=1 and `m_ready`=0.
  - One row is transferred per handshake cycle.
- `done` pulses the cycle after the last handshake. `busy` falls in the same cycle as `done`.
- `start` outside IDLE is ignored.

## Test plan
- Nominal, a_words=4, load_c=1, `s_valid`=1, `m_ready`=1: 41 words consumed → A strobes with `A_idx` 0..3, B_row 0..15, in_c_row 0..15, a single `write_cu`. A core model then returns 16 rows → 16 `m_valid` beats, `m_last` on beat 15, `done` on the following cycle.
- load_c=0, a_words=2: exactly 21 words consumed → 16 consecutive `write_c` pulses with `in_c`=0 and `s_ready`=0 throughout.
- Random `s_valid` gaps and `m_ready` toggling at 50%: strobe order, indices and D row order are unchanged; no row is duplicated or lost.
- Core model never asserts `core_out_valid`, TIMEOUT=64: after 64 COMPUTE cycles err=2'b01, `done` pulses, and `m_valid` is never asserted.
- `start` with a_words=17 (MAX 16) → err=2'b10, `busy` stays 0, `s_ready` stays 0. A following legal `start` clears `err`.
- Async reset asserted mid-LOAD_B: all outputs are 0 before the next clock edge. A fresh tile then completes correctly.
